// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed multi-digit seven-segment driver (optional decimal point: SEVSEG_DP_EN)
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
`ifdef SEVSEG_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp
`endif
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           index;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [3:0]              cur_digit;
    logic                    cur_sup;
    logic [NUM_DIGITS-1:0]   sup_vec;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    above_zero;
    logic [6:0]              seg_raw;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    // Active-low segment pattern for one nibble; 10-15 blank outside hex mode
    function automatic logic [6:0] decode(input logic [3:0] d, input logic hex);
        logic [6:0] r;
        case (d)
            4'd0:  r = 7'b1000000;
            4'd1:  r = 7'b1111001;
            4'd2:  r = 7'b0100100;
            4'd3:  r = 7'b0110000;
            4'd4:  r = 7'b0011001;
            4'd5:  r = 7'b0010010;
            4'd6:  r = 7'b0000010;
            4'd7:  r = 7'b1111000;
            4'd8:  r = 7'b0000000;
            4'd9:  r = 7'b0010000;
            4'd10: r = hex ? 7'b0001000 : 7'b1111111;
            4'd11: r = hex ? 7'b0000011 : 7'b1111111;
            4'd12: r = hex ? 7'b1000110 : 7'b1111111;
            4'd13: r = hex ? 7'b0100001 : 7'b1111111;
            4'd14: r = hex ? 7'b0000110 : 7'b1111111;
            default: r = hex ? 7'b0001110 : 7'b1111111;
        endcase
        return r;
    endfunction

    // Slot timer and digit index; index steps on the last cycle of each slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            index     <= '0;
        end else if (prescaler == PW'(CLK_DIV - 1)) begin
            prescaler <= '0;
            index     <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Shadow copy of the displayed value; last load wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        above_zero = 1'b1;
        sup_vec    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero & (shadow[4*i +: 4] == 4'd0);
            sup_vec[i] = above_zero && (i != 0);
        end
    end

    // Select the current digit, its suppression flag and its one-hot enable
    always_comb begin
        cur_digit = 4'd0;
        cur_sup   = 1'b0;
        onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur_digit = shadow[4*i +: 4];
                cur_sup   = sup_vec[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Next output pattern; the first cycle of each slot is a dark guard cycle
    always_comb begin
        seg_raw = (lz_blank && cur_sup) ? 7'b1111111 : decode(cur_digit, hex_mode);
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
        if (prescaler != '0) begin
            seg_nxt = (ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
            an_nxt  = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    // Registered segment and digit-enable lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

`ifdef SEVSEG_DP_EN
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic                  dp_on;

    // Decimal-point bits share the load strobe with the digit values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dp <= '0;
        end else if (load) begin
            shadow_dp <= dp_in;
        end
    end

    // Decimal point lights outside guard cycles and ignores zero suppression
    always_comb begin
        dp_on = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IW'(i)) begin
                dp_on = shadow_dp[i];
            end
        end
        dp_on = dp_on && (prescaler != '0);
    end

    // Registered decimal point output with selectable polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= (ACTIVE_LOW != 0);
        end else begin
            dp <= (ACTIVE_LOW != 0) ? ~dp_on : dp_on;
        end
    end
`endif

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Multi-digit, time-multiplexed seven-segment display driver: the parametrised successor to the team's single-digit combinational decoder.
- Holds a packed value for NUM_DIGITS digits in a shadow register and scans one digit per time slot.
- Drives shared, registered segment lines plus one-hot digit enables.
- Adds hex/decimal mode, leading-zero suppression, an anti-ghosting guard cycle and selectable output polarity.
- Sits between the SoC status/counter logic and the board's common-anode display.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 1..8.
- CLK_DIV, 50000: clk cycles per digit slot; minimum 2.
- ACTIVE_LOW, 1: 1 means seg, an (and dp) are active-low; 0 means they are active-high.

Ports:
- clk  input  1: single system clock; all state on rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- value  input  4*NUM_DIGITS: packed nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
- load  input  1: 1-cycle strobe; captures value into the shadow register.
- hex_mode  input  1: 1 decodes 0-F; 0 decodes 0-9 and blanks codes 10-15.
- lz_blank  input  1: 1 enables leading-zero suppression.
- seg  output  7: segments, seg[0]=a .. seg[6]=g; registered.
- an  output  NUM_DIGITS: one-hot digit enable; registered.

Behaviour:
- Reset (async assert, synchronous-safe release): prescaler=0, index=0, shadow=0, seg=all-off, an=all-off.
  - All-off means 7'b1111111 and all-ones an when ACTIVE_LOW=1; all-zeros when ACTIVE_LOW=0.
  - Reset mid-scan returns to this state immediately, with no glitch after release.
- Prescaler: counts 0..CLK_DIV-1 and wraps. At CLK_DIV-1, index advances by 1, wrapping NUM_DIGITS-1 to 0.
- Shadow: shadow <= value on the clk edge where load=1; otherwise it holds.
  - load is legal every cycle. Back-to-back loads: last one wins.
- Output register, every cycle, computed from the current prescaler, index and shadow:
  - Guard cycle (prescaler==0): seg=all-off, an=all-off. This prevents ghosting on digit change.
  - Otherwise: an = one-hot(index), seg = decode(shadow digit[index]).
- Latency: load at cycle t gives shadow at t+1 and a visible seg at t+2, provided t+2 is not a guard cycle. Otherwise it is visible at the next non-guard cycle showing that digit.
- Decode, active-low form (inverted when ACTIVE_LOW=0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - hex_mode=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - hex_mode=0: codes 10-15 give blank (1111111).
- Leading-zero suppression (lz_blank=1):
  - Digit i is blanked (seg all-off, an still asserted) if digit i and every digit above it are 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- hex_mode and lz_blank are sampled live each cycle and are not latched by load.
- NUM_DIGITS=1: index stays 0 and an toggles only around the guard cycle.

Optional Feature:
- Macro SEVSEG_DP_EN.
- Defined: adds port dp_in (input, NUM_DIGITS: decimal point per digit, latched into the shadow on load) and port dp (output, 1, registered).
  - dp is active when shadow dp bit[index] is 1 and the cycle is not a guard cycle. Polarity follows ACTIVE_LOW.
  - dp is off at reset, in guard cycles and when dp bit[index] is 0.
  - dp is not affected by leading-zero suppression.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1.
- Reset: hold rst_n=0, then release -> seg=1111111 and an=1111 until the first non-guard cycle. There, an=1110 and seg=1000000 (shadow=0, digit 0).
- Load and scan: load value=16'h1234, hex_mode=0, lz_blank=0 -> slots cycle as follows, each with an=1111 and seg=1111111 in its guard cycle:
  - an=1110, seg=0011001 (digit 4)
  - an=1101, seg=0110000 (digit 3)
  - an=1011, seg=0100100 (digit 2)
  - an=0111, seg=1111001 (digit 1)
- Mode switch: value=16'h00AF.
  - hex_mode=1 -> digit0 seg=0001110 (F), digit1 seg=0001000 (A).
  - hex_mode=0 -> both of those digits give 1111111.
- Leading-zero suppression: value=16'h0050, lz_blank=1 -> digits 3 and 2 give seg=1111111 with an asserted; digit1 seg=0010010 (5); digit0 seg=1000000 (0). With value=0, only digit0 shows 1000000.
- Load latency and async reset: pulse load at cycle t with a new digit-0 value while the slot is on digit 0 and t+2 is not a guard cycle -> seg changes exactly at t+2. Assert rst_n mid-slot -> outputs go all-off within the same cycle, without waiting for clk.
- SEVSEG_DP_EN: dp_in=4'b0100 on load -> dp=0 only in the non-guard cycles of digit 2's slot; dp=1 at all other times.
